bar_update_scheduler: RTL and testbench

BAR_UPDATE_SCHEDULER -- requirements
Module: bar_update_scheduler

---
 rtl/bar_update_scheduler.sv | 149 ++++++++++++++
 tb/tb_bar_update_scheduler.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bar_update_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : bar_update_scheduler
// Purpose : Runs one bar-height update pass per vertical-blanking interval.
//           For each bin it optionally fetches a spectrum sample, converts it
//           to a bar height, applies peak-hold with a per-frame decay, and
//           writes the resulting bar top row into the height table.
// Revision: 1.0 - initial release
// ============================================================================
module bar_update_scheduler #(
  parameter int NUM_BINS = 16,
  parameter int SCREEN_H = 480,
  parameter int SHIFT    = 6,
  parameter int DECAY    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        vblank,
  input  logic        fft_done,
  output logic        rd_req,
  output logic [3:0]  rd_addr,
  input  logic [15:0] rd_data,
  input  logic        rd_valid,
  output logic        height_we,
  output logic [3:0]  height_addr,
  output logic [8:0]  height_data,
  output logic        busy,
  output logic        frame_done,
  output logic        overrun
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_CALC  = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [3:0]  LAST_BIN   = 4'(NUM_BINS - 1);
  localparam logic [16:0] SCREEN_H17 = 17'(SCREEN_H);
  localparam logic [8:0]  SCREEN_H9  = 9'(SCREEN_H);
  localparam logic [8:0]  DECAY9     = 9'(DECAY);
  localparam logic [16:0] MAG_MAX    = 17'd32767;

  logic [2:0]  state;
  logic [2:0]  next_state;
  logic [3:0]  bin;
  logic        vblank_q;
  logic        pending;
  logic        fetch_mode;
  logic [15:0] sample;
  logic [8:0]  peak [NUM_BINS];

  logic        vblank_rise;
  logic        vblank_fall;
  logic        want_fetch;
  logic [16:0] sample_ext;
  logic [16:0] abs_val;
  logic [16:0] mag;
  logic [16:0] scaled;
  logic [8:0]  new_h;
  logic [8:0]  cur_peak;
  logic [8:0]  decayed;
  logic [8:0]  next_peak;

  assign vblank_rise = vblank & ~vblank_q;
  assign vblank_fall = ~vblank & vblank_q;
  // An fft_done arriving on the same cycle as the vblank edge still counts.
  assign want_fetch  = pending | fft_done;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= next_state;
  end

  // Next-state logic; vblank edges are only looked at while idle.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  if (vblank_rise) next_state = want_fetch ? S_FETCH : S_CALC;
      S_FETCH: if (rd_valid) next_state = S_CALC;
      S_CALC:  next_state = S_WRITE;
      S_WRITE: begin
        if (bin == LAST_BIN)  next_state = S_DONE;
        else if (fetch_mode)  next_state = S_FETCH;
        else                  next_state = S_CALC;
      end
      S_DONE:  next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // Height arithmetic: 17-bit absolute value so -32768 survives until saturation.
  always_comb begin
    sample_ext = {sample[15], sample};
    abs_val    = sample_ext[16] ? (~sample_ext + 17'd1) : sample_ext;
    if (!fetch_mode)            mag = '0;
    else if (abs_val > MAG_MAX) mag = MAG_MAX;
    else                        mag = abs_val;
    scaled   = mag >> SHIFT;
    new_h    = (scaled > SCREEN_H17) ? SCREEN_H9 : scaled[8:0];
    cur_peak = peak[bin];
    decayed  = (cur_peak > DECAY9) ? (cur_peak - DECAY9) : 9'd0;
    if (new_h >= cur_peak)    next_peak = new_h;
    else if (new_h > decayed) next_peak = new_h;
    else                      next_peak = decayed;
  end

  // Datapath registers: edge detect, pending flag, sample capture, peaks, bin, overrun.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // A blanking interval already in progress at release must not start a pass.
      vblank_q   <= 1'b1;
      pending    <= 1'b0;
      fetch_mode <= 1'b0;
      sample     <= '0;
      bin        <= '0;
      overrun    <= 1'b0;
      for (int i = 0; i < NUM_BINS; i++) peak[i] <= '0;
    end else begin
      vblank_q <= vblank;
      if (state == S_IDLE && vblank_rise) begin
        fetch_mode <= want_fetch;
        if (want_fetch) pending <= 1'b0;
        else if (fft_done) pending <= 1'b1;
      end else if (fft_done) begin
        pending <= 1'b1;
      end
      if (state == S_FETCH && rd_valid) sample <= rd_data;
      if (state == S_CALC) peak[bin] <= next_peak;
      if (state == S_WRITE && bin != LAST_BIN) bin <= bin + 4'd1;
      if (state == S_DONE) bin <= '0;
      if (state != S_IDLE && vblank_fall) overrun <= 1'b1;
    end
  end

  // Moore outputs decoded from the current state.
  always_comb begin
    rd_req      = (state == S_FETCH);
    rd_addr     = bin;
    height_we   = (state == S_WRITE);
    height_addr = (state == S_WRITE) ? bin : 4'd0;
    height_data = (state == S_WRITE) ? (SCREEN_H9 - peak[bin]) : SCREEN_H9;
    busy        = (state != S_IDLE);
    frame_done  = (state == S_DONE);
  end

endmodule
`default_nettype wire

// File: tb/tb_bar_update_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : tb_bar_update_scheduler
// Purpose : Scoreboard bench for bar_update_scheduler with a behavioural
//           peak-hold model and a randomised spectrum-memory responder.
// Revision: 1.0 - initial release
// ============================================================================
module tb_bar_update_scheduler;

  localparam int NB  = 16;
  localparam int H   = 480;
  localparam int SH  = 6;
  localparam int DEC = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        vblank;
  logic        fft_done;
  logic        rd_req;
  logic [3:0]  rd_addr;
  logic [15:0] rd_data;
  logic        rd_valid;
  logic        height_we;
  logic [3:0]  height_addr;
  logic [8:0]  height_data;
  logic        busy;
  logic        frame_done;
  logic        overrun;

  bar_update_scheduler #(.NUM_BINS(NB), .SCREEN_H(H), .SHIFT(SH), .DECAY(DEC)) dut (
    .clk(clk), .rst(rst), .vblank(vblank), .fft_done(fft_done),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
    .height_we(height_we), .height_addr(height_addr), .height_data(height_data),
    .busy(busy), .frame_done(frame_done), .overrun(overrun)
  );

  always #5 clk = ~clk;

  typedef struct {int addr; int data; int gap;} exp_t;
  exp_t sb[$];

  int checks = 0;
  int failures = 0;
  int cycle = 0;
  int last_wr = 0;
  int pass_writes = 0;
  int frames_seen = 0;
  int rdreq_cycles = 0;
  int cur_delay = 0;

  // reference model state
  logic signed [15:0] spec [NB];
  int  peak_m [NB];
  bit  pending_m = 0;
  bit  ovr_m = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cycle++;
  end

  // Monitor: every write strobe pops one expected entry.
  initial forever begin
    @(negedge clk);
    if (!rst && height_we) begin
      pass_writes++;
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL unexpected_write: got addr=%0d data=%0d expected none", height_addr, height_data);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (height_addr != e.addr || height_data != e.data) begin
          failures++;
          $display("FAIL write: got addr=%0d data=%0d expected addr=%0d data=%0d",
                   height_addr, height_data, e.addr, e.data);
        end
        if (e.gap > 0) chk("write_spacing", cycle - last_wr, e.gap);
      end
      last_wr = cycle;
    end
    if (!rst && frame_done) frames_seen++;
  end

  // Spectrum memory: answers rd_req after a configurable number of stall cycles.
  initial begin
    int wait_cnt;
    bit prev_req, prev_valid;
    logic [3:0] prev_addr;
    rd_valid = 0; rd_data = 0; wait_cnt = 0;
    prev_req = 0; prev_valid = 0; prev_addr = 0;
    forever begin
      @(negedge clk);
      if (rd_req) begin
        rdreq_cycles++;
        if (prev_req && !prev_valid) chk("rd_addr_stable", int'(rd_addr), int'(prev_addr));
        if (wait_cnt == 0) begin
          rd_valid = 1;
          rd_data  = spec[rd_addr];
        end else begin
          rd_valid = 0;
          rd_data  = 16'(int'($urandom));
          wait_cnt--;
        end
      end else begin
        rd_valid = 0;
        wait_cnt = (cur_delay < 0) ? int'($urandom_range(0, 3)) : cur_delay;
      end
      prev_req = rd_req; prev_valid = rd_valid; prev_addr = rd_addr;
    end
  end

  function automatic int next_peak(input int old, input int mag);
    int nh, dec;
    nh = mag >>> SH;
    if (nh > H) nh = H;
    if (nh >= old) return nh;
    dec = (old - DEC < 0) ? 0 : old - DEC;
    return (nh > dec) ? nh : dec;
  endfunction

  // Push the 16 writes a pass must produce.
  task automatic plan_pass(input bit fetch, input int delay);
    for (int i = 0; i < NB; i++) begin
      int d, a;
      exp_t e;
      d = int'(spec[i]);
      a = (d < 0) ? -d : d;
      if (a > 32767) a = 32767;
      if (!fetch) a = 0;
      peak_m[i] = next_peak(peak_m[i], a);
      e.addr = i;
      e.data = H - peak_m[i];
      e.gap  = (i == 0) ? 0 : (!fetch ? 2 : (delay == 0 ? 3 : 0));
      sb.push_back(e);
    end
  endtask

  task automatic pulse_fft();
    @(posedge clk); #1 fft_done = 1;
    @(posedge clk); #1 fft_done = 0;
    pending_m = 1;
  endtask

  task automatic run_pass(input bit fft_coinc, input int delay, input int drop_at);
    bit fetch, done;
    int f0;
    fetch = pending_m || fft_coinc;
    pending_m = 0;
    cur_delay = delay;
    plan_pass(fetch, delay);
    pass_writes = 0; rdreq_cycles = 0; f0 = frames_seen;
    @(posedge clk); #1 vblank = 1; fft_done = fft_coinc;
    @(posedge clk); #1 fft_done = 0;
    if (drop_at >= 0) ovr_m = 1;
    done = 0;
    for (int k = 0; k < 2000 && !done; k++) begin
      @(negedge clk);
      if (drop_at >= 0 && pass_writes > drop_at && vblank) vblank = 0;
      if (frame_done) done = 1;
    end
    chk("pass_completes", int'(done), 1);
    @(posedge clk); #1 vblank = 0;
    chk("frame_done_count", frames_seen - f0, 1);
    chk("writes_per_pass", pass_writes, NB);
    if (!fetch) chk("decay_no_rd_req", rdreq_cycles, 0);
    chk("overrun", int'(overrun), int'(ovr_m));
    chk("scoreboard_drained", sb.size(), 0);
  endtask

  task automatic check_reset_outputs();
    chk("rst_rd_req", int'(rd_req), 0);
    chk("rst_rd_addr", int'(rd_addr), 0);
    chk("rst_height_we", int'(height_we), 0);
    chk("rst_height_addr", int'(height_addr), 0);
    chk("rst_height_data", int'(height_data), H);
    chk("rst_busy", int'(busy), 0);
    chk("rst_frame_done", int'(frame_done), 0);
    chk("rst_overrun", int'(overrun), 0);
  endtask

  task automatic rand_spec();
    for (int i = 0; i < NB; i++) begin
      case ($urandom_range(0, 3))
        0:       spec[i] = -16'sd32768;
        1:       spec[i] = 16'(int'($urandom_range(0, 4000)));
        default: spec[i] = 16'(int'($urandom));
      endcase
    end
  endtask

  initial begin
    int w0;
    bit hit;
    rst = 1; vblank = 0; fft_done = 0;
    for (int i = 0; i < NB; i++) begin peak_m[i] = 0; spec[i] = 0; end
    repeat (3) @(posedge clk);
    #1 check_reset_outputs();
    rst = 0;

    // Nominal: every bin 3200 -> height 50 -> row 430
    for (int i = 0; i < NB; i++) spec[i] = 16'sd3200;
    pulse_fft();
    run_pass(0, 0, -1);

    // Saturation corners
    for (int i = 0; i < NB; i++) spec[i] = 16'(int'($urandom_range(0, 2000)));
    spec[3] = -16'sd32768;
    spec[9] = -16'sd6400;
    pulse_fft();
    run_pass(0, 0, -1);

    // Decay-only pass, then a fetch coinciding with the vblank edge
    run_pass(0, 0, -1);
    for (int i = 0; i < NB; i++) spec[i] = 16'sd640;
    run_pass(1, 0, -1);

    // Handshake stall of three cycles per read
    rand_spec();
    pulse_fft();
    run_pass(0, 3, -1);

    // Overrun: blanking ends after bin 7, pass must still finish
    rand_spec();
    pulse_fft();
    run_pass(0, 0, 7);
    run_pass(0, -1, -1);

    // Random mix of fetch/decay passes with random stalls
    for (int p = 0; p < 8; p++) begin
      bit coinc;
      rand_spec();
      coinc = $urandom_range(0, 3) == 0;
      if (!coinc && $urandom_range(0, 2) != 0) pulse_fft();
      run_pass(coinc, ($urandom_range(0, 1) == 0) ? 0 : -1, -1);
    end

    // Reset in the middle of a pass
    rand_spec();
    pulse_fft();
    pending_m = 0;
    cur_delay = 0;
    plan_pass(1, 0);
    pass_writes = 0;
    @(posedge clk); #1 vblank = 1;
    hit = 0;
    for (int k = 0; k < 500 && !hit; k++) begin
      @(negedge clk);
      if (pass_writes >= 5) hit = 1;
    end
    chk("reached_bin5", int'(hit), 1);
    #2 rst = 1;
    #1 check_reset_outputs();
    sb.delete();
    for (int i = 0; i < NB; i++) peak_m[i] = 0;
    pending_m = 0; ovr_m = 0;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    w0 = pass_writes;
    repeat (12) @(negedge clk);
    chk("no_restart_busy", int'(busy), 0);
    chk("no_writes_after_rst", pass_writes - w0, 0);
    @(posedge clk); #1 vblank = 0;
    run_pass(0, 0, -1);
    rand_spec();
    pulse_fft();
    run_pass(0, -1, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
